// File: rtl/mult_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : mult_serial_host
// Description : Host-side sequencer for a serial signed WxW multiplier.
//               Shifts parallel operands into the multiplier's x/y serial
//               ports, triggers the multiply, shifts the 2W-bit product back
//               out of the z port and presents it in parallel with a pulse.
//               Every wait on the multiplier is bounded by TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_serial_host #(
    parameter int W       = 12,
    parameter int Z_LAT   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             busy,
    output logic [2*W-1:0]   z,
    output logic             z_valid,
    output logic             err,
    output logic             x_in,
    output logic             sx,
    output logic             y_in,
    output logic             sy,
    input  logic             fx,
    input  logic             fy,
    output logic             mul,
    input  logic             done,
    output logic             sz,
    input  logic             z_out,
    input  logic             fz
);

    localparam int CW = $clog2(Z_LAT + 2*W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_LOAD_LAST    = CW'(W - 1);
    localparam logic [CW-1:0] c_SAMPLE_FIRST = CW'(Z_LAT);
    localparam logic [CW-1:0] c_UNLOAD_LAST  = CW'(Z_LAT + 2*W - 1);
    localparam logic [TW-1:0] c_TIMEOUT      = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_F    = 3'd2,
        S_MUL       = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_UNLOAD    = 3'd5,
        S_WAIT_FZ   = 3'd6,
        S_RESULT    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     xs_q, xs_d;
    logic [W-1:0]     ys_q, ys_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [2*W-1:0]   cap_q, cap_d;
    logic [2*W-1:0]   z_q, z_d;
    logic             w_timeout;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            cap_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            cap_q   <= cap_d;
            z_q     <= z_d;
        end
    end

    // A wait condition seen in the same cycle as the limit wins over the abort.
    assign w_timeout = (wcnt_q == c_TIMEOUT);

    assign busy = (state_q != S_IDLE);
    assign z    = z_q;

    // Next-state, counters, shift registers and serial-side outputs.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        cap_d   = cap_q;
        z_d     = z_q;
        z_valid = 1'b0;
        err     = 1'b0;
        x_in    = 1'b0;
        y_in    = 1'b0;
        sx      = 1'b0;
        sy      = 1'b0;
        mul     = 1'b0;
        sz      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                sx    = 1'b1;
                sy    = 1'b1;
                x_in  = xs_q[0];
                y_in  = ys_q[0];
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LOAD_LAST) begin
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = S_WAIT_F;
                end
            end

            S_WAIT_F: begin
                wcnt_d = wcnt_q + 1'b1;
                if (fx && fy) begin
                    state_d = S_MUL;
                end else if (w_timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_MUL: begin
                mul     = 1'b1;
                wcnt_d  = '0;
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                wcnt_d = wcnt_q + 1'b1;
                if (done) begin
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end else if (w_timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_UNLOAD: begin
                sz    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // Product arrives LSB first; shifting in at the top lands bit 0 at the bottom.
                if (cnt_q >= c_SAMPLE_FIRST) begin
                    cap_d = {z_out, cap_q[2*W-1:1]};
                end
                if (cnt_q == c_UNLOAD_LAST) begin
                    cnt_d = '0;
                    if (fz) begin
                        z_d     = cap_d;
                        state_d = S_RESULT;
                    end else begin
                        wcnt_d  = '0;
                        state_d = S_WAIT_FZ;
                    end
                end
            end

            S_WAIT_FZ: begin
                wcnt_d = wcnt_q + 1'b1;
                if (fz) begin
                    z_d     = cap_q;
                    state_d = S_RESULT;
                end else if (w_timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_RESULT: begin
                z_valid = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
